led_pulse_stretch: RTL

Output-side counterpart to the switch debouncer: it turns short internal events (rising edges of a one-bit signal, e.g. a debounced switch or a one-cycle strobe) into human-visible LED blinks of a fixed minimum on-time, separated by a fixed off-gap. Events that arrive while a blink is in progress are queued and replayed as further blinks, up to a saturating limit. It sits between core logic and a board LED pin on the single 25 MHz system clock.

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_pulse_stretch_if.sv | 24 ++
 rtl/led_pulse_stretch_rise_detect.sv | 27 ++
 rtl/led_pulse_stretch.sv | 133 +++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED pulse stretcher.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package led_pkg;

  // Blink sequencer states; encoding is fixed so it can be decoded externally.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } led_state_e;

  // One counter serves both the on-phase and the gap-phase.
  localparam int unsigned C_CNT_W = 22;

  // Pending-event counter width; holds up to 7 queued events.
  localparam int unsigned C_PEND_W = 3;

  // Defaults for a 25 MHz clock: 100 ms on, 50 ms off, up to 7 queued events.
  localparam int unsigned C_ON_LIMIT_DEF    = 2500000;
  localparam int unsigned C_GAP_LIMIT_DEF   = 1250000;
  localparam int unsigned C_PENDING_MAX_DEF = 7;

endpackage

// File: rtl/led_pulse_stretch_if.sv
// Event input and LED/status outputs of the pulse stretcher.
// Latency: n/a (signal bundle only).
// Backpressure: none; events are never stalled, only queued or dropped.
interface led_pulse_stretch_if;
  import led_pkg::*;

  logic                i_Event;
  logic                o_LED;
  logic                o_Busy;
  logic [C_PEND_W-1:0] o_Pending;
  logic                o_Overflow;

  // Core logic side: raises events, observes LED and status.
  modport master (
    output i_Event,
    input  o_LED, o_Busy, o_Pending, o_Overflow
  );

  // Stretcher side: consumes events, drives LED and status.
  modport slave (
    input  i_Event,
    output o_LED, o_Busy, o_Pending, o_Overflow
  );
endinterface

// File: rtl/led_pulse_stretch_rise_detect.sv
// Rising-edge detector producing a one-cycle strobe per 0->1 transition.
// Latency: strobe is combinational in the cycle the input goes high.
// Backpressure: none.
module rise_detect #(
  // Reset value of the history register; 1 hides a level held high across reset.
  parameter logic p_RST_VAL = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Sig,
  output logic o_Rise
);

  logic r_Event_d;

  // Remember last cycle's input level.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Event_d <= p_RST_VAL;
    end else begin
      r_Event_d <= i_Sig;
    end
  end

  assign o_Rise = i_Sig & ~r_Event_d;

endmodule

// File: rtl/led_pulse_stretch.sv
// Stretches input events into fixed-length LED blinks with a forced off-gap.
// Latency: event in cycle t lights the LED from cycle t+1; all outputs registered.
// Backpressure: none; events during a blink queue (LED_STRETCH_QUEUE_EN) or drop and set overflow.
module led_pulse_stretch
  import led_pkg::*;
#(
  parameter int unsigned c_ON_LIMIT    = C_ON_LIMIT_DEF,
  parameter int unsigned c_GAP_LIMIT   = C_GAP_LIMIT_DEF,
  parameter int unsigned c_PENDING_MAX = C_PENDING_MAX_DEF
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  led_pulse_stretch_if.slave  bus
);

  localparam logic [C_CNT_W-1:0]  ON_LAST  = C_CNT_W'(c_ON_LIMIT - 1);
  localparam logic [C_CNT_W-1:0]  GAP_LAST = C_CNT_W'(c_GAP_LIMIT - 1);
  localparam logic [C_PEND_W-1:0] PEND_CFG = C_PEND_W'(c_PENDING_MAX);

`ifdef LED_STRETCH_QUEUE_EN
  localparam bit QUEUE_EN = 1'b1;
`else
  localparam bit QUEUE_EN = 1'b0;
`endif

  // Without the queue the capacity is zero, so every busy-time event overflows.
  localparam logic [C_PEND_W-1:0] PEND_CAP = QUEUE_EN ? PEND_CFG : '0;

  led_state_e          state_q;
  logic [C_CNT_W-1:0]  r_Count;
  logic [C_PEND_W-1:0] pending_q, pending_d;
  logic                ovf_q, ovf_d;
  logic                led_q;
  logic                busy_q;
  logic                rise;
  logic                last_gap;
  logic                pend_dec;
  logic                busy_evt;

  rise_detect #(
    .p_RST_VAL (1'b1)
  ) u_rise (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Sig  (bus.i_Event),
    .o_Rise (rise)
  );

  assign last_gap = (state_q == GAP) && (r_Count == GAP_LAST);
  assign pend_dec = last_gap && (pending_q != '0);
  assign busy_evt = rise && (state_q != IDLE);

  // Queue accounting: an event coinciding with a replay leaves the count unchanged.
  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    if (busy_evt) begin
      if (pend_dec) begin
        pending_d = pending_q;
      end else if (pending_q < PEND_CAP) begin
        pending_d = pending_q + C_PEND_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pend_dec) begin
      pending_d = pending_q - C_PEND_W'(1);
    end
  end

  // Blink sequencer with registered LED/busy outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      r_Count   <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= ON;
            r_Count <= '0;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ON: begin
          if (r_Count == ON_LAST) begin
            state_q <= GAP;
            r_Count <= '0;
            led_q   <= 1'b0;
          end else begin
            r_Count <= r_Count + C_CNT_W'(1);
          end
        end
        GAP: begin
          if (r_Count == GAP_LAST) begin
            r_Count <= '0;
            if (pend_dec) begin
              state_q <= ON;
              led_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            r_Count <= r_Count + C_CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          r_Count <= '0;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_LED      = led_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Overflow = ovf_q;
`ifdef LED_STRETCH_QUEUE_EN
  assign bus.o_Pending  = pending_q;
`else
  assign bus.o_Pending  = '0;
`endif

endmodule
